// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment scanner with frame-synchronous display update
// Prescaled digit scan, BCD/hex decode, leading-zero blanking and tear-free double buffering.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 5,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   SEG_SEL,
  output logic [7:0]              SEG_DATA,
  output logic                    frame_pulse
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0]         PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_v;

  logic                    w_tick;
  logic                    w_wrap;
  logic [IW-1:0]           w_idx_next;
  logic [4*NUM_DIGITS-1:0] w_disp_next;
  logic [NUM_DIGITS-1:0]   w_dp_next;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_all_zero;
  logic [3:0]              w_code;
  logic                    w_dp_sel;
  logic                    w_blank_sel;
  logic [6:0]              w_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = hex ? 7'h77 : 7'h40;
      4'hB: seg = hex ? 7'h7C : 7'h40;
      4'hC: seg = hex ? 7'h39 : 7'h40;
      4'hD: seg = hex ? 7'h5E : 7'h40;
      4'hE: seg = hex ? 7'h79 : 7'h40;
      default: seg = hex ? 7'h71 : 7'h40;
    endcase
    return seg;
  endfunction

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_wrap     = w_tick && (r_idx == IDX_MAX);
  assign w_idx_next = (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);

  // The digit shown on the wrap tick already belongs to the new frame.
  assign w_disp_next = !w_wrap ? r_disp    : (load ? data_in : (r_pend_v ? r_pend    : r_disp));
  assign w_dp_next   = !w_wrap ? r_dp      : (load ? dp_in   : (r_pend_v ? r_pend_dp : r_dp));

  always_comb begin
    w_blank    = '0;
    w_all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_all_zero = w_all_zero && (w_disp_next[4*i +: 4] == 4'd0);
      w_blank[i] = blank_lz && w_all_zero;
    end
  end

  always_comb begin
    w_code      = 4'd0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == IW'(i)) begin
        w_code      = w_disp_next[4*i +: 4];
        w_dp_sel    = w_dp_next[i];
        w_blank_sel = w_blank[i];
      end
    end
  end

  assign w_seg = w_blank_sel ? 7'd0 : seg_decode(w_code, hex_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_dp        <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_v    <= 1'b0;
      SEG_SEL     <= SEL_ONE;
      SEG_DATA    <= 8'h00;
      frame_pulse <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + PW'(1);
      frame_pulse <= w_wrap;
      if (w_tick) begin
        r_idx    <= w_idx_next;
        SEG_SEL  <= SEL_ONE << w_idx_next;
        SEG_DATA <= {w_dp_sel, w_seg};
      end
      if (w_wrap) begin
        r_disp   <= w_disp_next;
        r_dp     <= w_dp_next;
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend    <= data_in;
        r_pend_dp <= dp_in;
        r_pend_v  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [19:0] data_in  = '0;
  logic [4:0]  dp_in    = '0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [4:0]  SEG_SEL;
  logic [7:0]  SEG_DATA;
  logic        frame_pulse;

  int checks   = 0;
  int failures = 0;

  seven_seg_scanner #(.NUM_DIGITS(5), .SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
    .SEG_SEL     (SEG_SEL),
    .SEG_DATA    (SEG_DATA),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    checks++;
    if (SEG_SEL !== 5'b00001) begin
      failures++; $display("FAIL reset_sel got=%b exp=00001", SEG_SEL);
    end
    checks++;
    if (SEG_DATA !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", SEG_DATA);
    end
    checks++;
    if (frame_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_frame got=%b exp=0", frame_pulse);
    end
  endtask

  task automatic test_scan_sequence;
    logic [4:0] e_sel;
    logic [7:0] e_data;
    logic       e_fp;
    rst_n = 1'b1;
    for (int p = 0; p <= 24; p++) begin
      if (p > 0) step(1);
      e_sel  = 5'(1 << ((p / 4) % 5));
      e_fp   = (p > 0) && (p % 20 == 0);
      e_data = (p < 4) ? 8'h00 : 8'h3F;
      checks++;
      if (SEG_SEL !== e_sel || SEG_DATA !== e_data || frame_pulse !== e_fp) begin
        failures++;
        $display("FAIL scan_p%0d got sel=%b data=%h fp=%b exp sel=%b data=%h fp=%b",
                 p, SEG_SEL, SEG_DATA, frame_pulse, e_sel, e_data, e_fp);
      end
    end
  endtask

  task automatic test_bcd_load;
    logic [7:0] e_seg [5];
    bit ok;
    e_seg = '{8'h3F, 8'h06, 8'hDB, 8'h4F, 8'h66};
    hex_mode = 1'b0; blank_lz = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bcd_sync got=no_frame exp=frame_pulse"); end
    step(8);
    data_in = 20'h43210; dp_in = 5'b00100; load = 1'b1;
    step(1);
    load = 1'b0;
    checks++;
    if (SEG_SEL !== 5'b00100 || SEG_DATA !== 8'h3F) begin
      failures++; $display("FAIL bcd_old_d2 got sel=%b data=%h exp sel=00100 data=3F", SEG_SEL, SEG_DATA);
    end
    step(3);
    checks++;
    if (SEG_SEL !== 5'b01000 || SEG_DATA !== 8'h3F) begin
      failures++; $display("FAIL bcd_old_d3 got sel=%b data=%h exp sel=01000 data=3F", SEG_SEL, SEG_DATA);
    end
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bcd_sync2 got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== e_seg[d]) begin
        failures++;
        $display("FAIL bcd_d%0d got sel=%b data=%h exp sel=%b data=%h", d, SEG_SEL, SEG_DATA, 5'(1 << d), e_seg[d]);
      end
      step(4);
    end
  endtask

  task automatic test_hex;
    logic [7:0] e_seg [5];
    bit ok;
    e_seg = '{8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    hex_mode = 1'b1;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hex_sync got=no_frame exp=frame_pulse"); end
    data_in = 20'hFEDCB; dp_in = 5'b00000; load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hex_sync2 got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== e_seg[d]) begin
        failures++;
        $display("FAIL hex_d%0d got sel=%b data=%h exp sel=%b data=%h", d, SEG_SEL, SEG_DATA, 5'(1 << d), e_seg[d]);
      end
      step(4);
    end
    hex_mode = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dash_sync got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== 8'h40) begin
        failures++;
        $display("FAIL dash_d%0d got sel=%b data=%h exp sel=%b data=40", d, SEG_SEL, SEG_DATA, 5'(1 << d));
      end
      step(4);
    end
  endtask

  task automatic test_blank;
    logic [7:0] e_seg [5];
    bit ok;
    e_seg = '{8'h3F, 8'h07, 8'h00, 8'h00, 8'h00};
    blank_lz = 1'b1; hex_mode = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL blank_sync got=no_frame exp=frame_pulse"); end
    data_in = 20'h00070; dp_in = 5'b00000; load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL blank_sync2 got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== e_seg[d]) begin
        failures++;
        $display("FAIL blank_d%0d got sel=%b data=%h exp sel=%b data=%h", d, SEG_SEL, SEG_DATA, 5'(1 << d), e_seg[d]);
      end
      step(4);
    end
    e_seg = '{8'h3F, 8'h00, 8'h80, 8'h00, 8'h00};
    data_in = 20'h00000; dp_in = 5'b00100; load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zero_sync got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== e_seg[d]) begin
        failures++;
        $display("FAIL zero_d%0d got sel=%b data=%h exp sel=%b data=%h", d, SEG_SEL, SEG_DATA, 5'(1 << d), e_seg[d]);
      end
      step(4);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_wrap_load;
    bit ok;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_sync got=no_frame exp=frame_pulse"); end
    step(19);
    data_in = 20'h00009; dp_in = 5'b00000; load = 1'b1;
    step(1);
    load = 1'b0;
    checks++;
    if (frame_pulse !== 1'b1 || SEG_SEL !== 5'b00001 || SEG_DATA !== 8'h6F) begin
      failures++;
      $display("FAIL wrap_d0 got fp=%b sel=%b data=%h exp fp=1 sel=00001 data=6F", frame_pulse, SEG_SEL, SEG_DATA);
    end
    for (int d = 1; d < 5; d++) begin
      step(4);
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== 8'h3F) begin
        failures++;
        $display("FAIL wrap_d%0d got sel=%b data=%h exp sel=%b data=3F", d, SEG_SEL, SEG_DATA, 5'(1 << d));
      end
    end
    step(4);
    checks++;
    if (frame_pulse !== 1'b1 || SEG_DATA !== 8'h6F) begin
      failures++; $display("FAIL wrap_next got fp=%b data=%h exp fp=1 data=6F", frame_pulse, SEG_DATA);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_sync got=no_frame exp=frame_pulse"); end
    data_in = 20'h11111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(5);
    data_in = 20'h22222; load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_sync2 got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== 8'h5B) begin
        failures++;
        $display("FAIL b2b_d%0d got sel=%b data=%h exp sel=%b data=5B", d, SEG_SEL, SEG_DATA, 5'(1 << d));
      end
      step(4);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL arst_sync got=no_frame exp=frame_pulse"); end
    data_in = 20'h88888; dp_in = 5'b11111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(8);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (SEG_SEL !== 5'b00001 || SEG_DATA !== 8'h00 || frame_pulse !== 1'b0) begin
      failures++;
      $display("FAIL arst_async got sel=%b data=%h fp=%b exp sel=00001 data=00 fp=0", SEG_SEL, SEG_DATA, frame_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (SEG_SEL !== 5'b00001 || SEG_DATA !== 8'h00) begin
      failures++; $display("FAIL arst_held got sel=%b data=%h exp sel=00001 data=00", SEG_SEL, SEG_DATA);
    end
    step(4);
    checks++;
    if (SEG_SEL !== 5'b00010 || SEG_DATA !== 8'h3F) begin
      failures++; $display("FAIL arst_first_tick got sel=%b data=%h exp sel=00010 data=3F", SEG_SEL, SEG_DATA);
    end
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL arst_sync2 got=no_frame exp=frame_pulse"); end
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (SEG_SEL !== 5'(1 << d) || SEG_DATA !== 8'h3F) begin
        failures++;
        $display("FAIL arst_d%0d got sel=%b data=%h exp sel=%b data=3F", d, SEG_SEL, SEG_DATA, 5'(1 << d));
      end
      step(4);
    end
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_bcd_load();
    test_hex();
    test_blank();
    test_wrap_load();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
